vga_timing_pipe: RTL and testbench
==================================

// Module: vga_timing_pipe
// PURPOSE
//  Parametrised VGA raster engine: pixel-rate H/V counters, sync/blank generation,
//  framebuffer coordinates and a latency-matched RGB output stage. Sits between
//  pixel_clk (DCM output) and the vr/vg/vb/hsync/vsync pins. Replaces hard-coded
//  1280x800 timing with configurable mode, sync polarity, clock divide and pipeline delay.
// PARAMETERS
//  H_ACTIVE 1280  visible pixels/line;  H_FP 64  front porch;  H_SYNC 136  sync width;  H_BP 200  back porch
//  V_ACTIVE 800   visible lines;  V_FP 1  front porch;  V_SYNC 3  sync lines;  V_BP 24  back porch
//  HSYNC_POL 0    level of hsync during sync pulse (0 = active low)
//  VSYNC_POL 1    level of vsync during sync pulse (1 = active high)
//  HW 12 / VW 11  hpos / vpos width; require H_TOTAL <= 2**HW, V_TOTAL <= 2**VW
//  CLK_DIV 1      pixel_clk cycles per pixel (>=1)
//  PIPE_LAT 2     pixel steps between position output and rgb_in valid (>=0)
//  SCALE_LOG2 3   framebuffer scaling: fb_x = hpos>>SCALE_LOG2, fb_y = vpos>>SCALE_LOG2
//  CW 5           bits per colour channel
// PORTS
//  pixel_clk    in   1          clock
//  rst          in   1          synchronous, active-high reset
//  pix_ce       out  1          pixel step strobe; all counters/pipes advance only when high
//  hpos         out  HW         current column counter, 0..H_TOTAL-1
//  vpos         out  VW         current line counter, 0..V_TOTAL-1
//  fb_x         out  HW-SCALE_LOG2  hpos>>SCALE_LOG2
//  fb_y         out  VW-SCALE_LOG2  vpos>>SCALE_LOG2
//  line_start   out  1          pix_ce & hpos==0
//  frame_start  out  1          pix_ce & hpos==0 & vpos==0
//  rgb_in       in   3*CW       {r,g,b} for position issued PIPE_LAT pixel steps earlier
//  test_pattern in   1          gradient select (only used when VGA_TEST_PATTERN_EN defined)
//  vr/vg/vb     out  CW each    registered colour, zero while blanked
//  hsync/vsync  out  1          registered sync, polarity per *_POL
//  blank        out  1          registered, 1 outside active area
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; all arithmetic unsigned.
//  - Divider: div counts 0..CLK_DIV-1; pix_ce = (div==CLK_DIV-1); CLK_DIV=1 -> pix_ce=1 always.
//  - On pix_ce: hpos==H_TOTAL-1 -> hpos<=0 and vpos advances (V_TOTAL-1 -> 0); else hpos+1.
//  - Raw stage (from counters): hs_act = H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC;
//    vs_act = V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC; blk = hpos>=H_ACTIVE | vpos>=V_ACTIVE.
//  - Delay line: {hs_act,vs_act,blk} shifted PIPE_LAT stages, each stage loads on pix_ce only.
//  - Output regs load on pix_ce: hsync = hs_d ? HSYNC_POL : ~HSYNC_POL (vsync same);
//    blank = blk_d; {vr,vg,vb} = blk_d ? 0 : rgb_in. Counter-to-pin latency = PIPE_LAT+1 steps.
//  - Between pix_ce strobes every register holds.
//  - Reset (any cycle, incl. mid-line): div=0, hpos=0, vpos=0, delay stages = {0,0,1},
//    blank=1, rgb=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL. First pix_ce after reset
//    asserts frame_start and line_start (counters at 0,0).
//  - rst and pix_ce in same cycle: reset wins, no advance.
//  - line_start/frame_start combinational from counter regs and pix_ce; 1 pixel_clk wide.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: when test_pattern=1, rgb_in ignored and output stage uses
//    the delayed position: r = vpos_d[8:4], g = hpos_d[8:4], b = hpos_d[8:4]^vpos_d[8:4]
//    (taken mod CW bits, zero-extended if CW>5), still zeroed when blanked; hpos/vpos
//    delayed through the same PIPE_LAT stages.
//  Undefined: test_pattern unused, no position delay registers; output = rgb_in path only.
// TESTING  (small mode: H 8/2/3/3 -> H_TOTAL 16; V 4/1/2/1 -> V_TOTAL 8; CLK_DIV 1, PIPE_LAT 2)
//  - Free-run 3 frames -> frame_start every 128 cycles, line_start every 16; hpos 15->0 with vpos+1; vpos 7->0.
//  - hsync sampled vs hpos lagged 3 cycles -> level HSYNC_POL exactly for hpos 10..12; vsync=VSYNC_POL for vpos 5..6.
//  - rgb_in = {hpos lagged 2} -> vr/vg/vb equal hpos lagged 3 for hpos 0..7, 0 for 8..15; blank=1 matches.
//  - CLK_DIV=3 -> pix_ce 1-in-3; hpos/outputs change only on pix_ce cycles; frame = 384 cycles.
//  - Assert rst at hpos=5,vpos=2 for 1 cycle -> next cycle hpos=0,vpos=0,blank=1,rgb=0,syncs inactive; then frame_start.
//  - VGA_TEST_PATTERN_EN, test_pattern=1, default mode -> at hpos_d=32,vpos_d=16: vr=1, vg=2, vb=3.

Source files
------------

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster engine: pixel-step divider, H/V counters, sync/blank, fb coords, latency-matched RGB stage.
// Optional feature: define VGA_TEST_PATTERN_EN for a built-in position gradient selected by i_test_pattern.
module vga_timing_pipe #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 64,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 200,
  parameter int V_ACTIVE   = 800,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 24,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int HW         = 12,
  parameter int VW         = 11,
  parameter int CLK_DIV    = 1,
  parameter int PIPE_LAT   = 2,
  parameter int SCALE_LOG2 = 3,
  parameter int CW         = 5
) (
  input  logic                   i_pixel_clk,
  input  logic                   i_rst,
  output logic                   o_pix_ce,
  output logic [HW-1:0]          o_hpos,
  output logic [VW-1:0]          o_vpos,
  output logic [HW-SCALE_LOG2-1:0] o_fb_x,
  output logic [VW-SCALE_LOG2-1:0] o_fb_y,
  output logic                   o_line_start,
  output logic                   o_frame_start,
  input  logic [3*CW-1:0]        i_rgb_in,
  input  logic                   i_test_pattern,
  output logic [CW-1:0]          o_vr,
  output logic [CW-1:0]          o_vg,
  output logic [CW-1:0]          o_vb,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

`ifdef VGA_TEST_PATTERN_EN
  localparam int PW = 3 + HW + VW;
`else
  localparam int PW = 3;
`endif
  // Stage reset value: syncs inactive, blanked, position zero.
  localparam logic [PW-1:0] STAGE_RST = PW'(3'b001);

  logic [DW-1:0]   r_div;
  logic [HW-1:0]   r_hpos;
  logic [VW-1:0]   r_vpos;
  logic            w_pix_ce;
  logic            w_hs_raw;
  logic            w_vs_raw;
  logic            w_blk_raw;
  logic [PW-1:0]   w_stage_raw;
  logic [PW-1:0]   w_stage_d;
  logic            w_hs_d;
  logic            w_vs_d;
  logic            w_blk_d;
  logic [3*CW-1:0] w_rgb_src;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_blank;
  logic [3*CW-1:0] r_rgb;

  assign w_pix_ce = (r_div == DIV_LAST);

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) begin
      r_div  <= '0;
      r_hpos <= '0;
      r_vpos <= '0;
    end else begin
      r_div <= w_pix_ce ? '0 : r_div + 1'b1;
      if (w_pix_ce) begin
        if (r_hpos == H_LAST) begin
          r_hpos <= '0;
          r_vpos <= (r_vpos == V_LAST) ? '0 : r_vpos + 1'b1;
        end else begin
          r_hpos <= r_hpos + 1'b1;
        end
      end
    end
  end

  assign w_hs_raw  = (int'(r_hpos) >= H_ACTIVE + H_FP) && (int'(r_hpos) < H_ACTIVE + H_FP + H_SYNC);
  assign w_vs_raw  = (int'(r_vpos) >= V_ACTIVE + V_FP) && (int'(r_vpos) < V_ACTIVE + V_FP + V_SYNC);
  assign w_blk_raw = (int'(r_hpos) >= H_ACTIVE) || (int'(r_vpos) >= V_ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
  assign w_stage_raw = {r_hpos, r_vpos, w_hs_raw, w_vs_raw, w_blk_raw};
`else
  assign w_stage_raw = {w_hs_raw, w_vs_raw, w_blk_raw};
`endif

  generate
    if (PIPE_LAT == 0) begin : g_no_pipe
      assign w_stage_d = w_stage_raw;
    end else begin : g_pipe
      logic [PW-1:0] r_pipe [PIPE_LAT];
      always_ff @(posedge i_pixel_clk) begin
        if (i_rst) begin
          for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= STAGE_RST;
        end else if (w_pix_ce) begin
          r_pipe[0] <= w_stage_raw;
          for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_stage_d = r_pipe[PIPE_LAT-1];
    end
  endgenerate

  assign w_hs_d  = w_stage_d[2];
  assign w_vs_d  = w_stage_d[1];
  assign w_blk_d = w_stage_d[0];

`ifdef VGA_TEST_PATTERN_EN
  logic [HW-1:0] w_hpos_d;
  logic [VW-1:0] w_vpos_d;
  logic [4:0]    w_h5;
  logic [4:0]    w_v5;
  assign w_hpos_d = w_stage_d[PW-1 -: HW];
  assign w_vpos_d = w_stage_d[3 +: VW];
  // Bits [8:4] of the delayed position; zero-extended first so narrow counters still work.
  assign w_h5 = 5'((HW+9)'(w_hpos_d) >> 4);
  assign w_v5 = 5'((VW+9)'(w_vpos_d) >> 4);
  assign w_rgb_src = i_test_pattern ? {CW'(w_v5), CW'(w_h5), CW'(w_h5 ^ w_v5)} : i_rgb_in;
`else
  logic w_unused_test_pattern;
  assign w_unused_test_pattern = i_test_pattern;
  assign w_rgb_src = i_rgb_in;
`endif

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) begin
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_blank <= 1'b1;
      r_rgb   <= '0;
    end else if (w_pix_ce) begin
      r_hsync <= w_hs_d ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= w_vs_d ? VSYNC_POL : ~VSYNC_POL;
      r_blank <= w_blk_d;
      r_rgb   <= w_blk_d ? '0 : w_rgb_src;
    end
  end

  assign o_pix_ce      = w_pix_ce;
  assign o_hpos        = r_hpos;
  assign o_vpos        = r_vpos;
  assign o_fb_x        = r_hpos[HW-1:SCALE_LOG2];
  assign o_fb_y        = r_vpos[VW-1:SCALE_LOG2];
  assign o_line_start  = w_pix_ce && (r_hpos == '0);
  assign o_frame_start = w_pix_ce && (r_hpos == '0) && (r_vpos == '0);
  assign o_vr          = r_rgb[3*CW-1 -: CW];
  assign o_vg          = r_rgb[2*CW-1 -: CW];
  assign o_vb          = r_rgb[CW-1:0];
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_blank       = r_blank;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe in the small mode (H_TOTAL 16, V_TOTAL 8), one instance at CLK_DIV 1 and one at CLK_DIV 3.
module tb_vga_timing_pipe;

  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [3*CW-1:0] rgb_in;
  logic test_pattern;

  logic          ce_1, ls_1, fs_1, hs_1, vs_1, bl_1;
  logic [3:0]    hpos_1;
  logic [2:0]    vpos_1, fbx_1;
  logic [1:0]    fby_1;
  logic [CW-1:0] vr_1, vg_1, vb_1;

  logic          ce_3, ls_3, fs_3, hs_3, vs_3, bl_3;
  logic [3:0]    hpos_3;
  logic [2:0]    vpos_3, fbx_3;
  logic [1:0]    fby_3;
  logic [CW-1:0] vr_3, vg_3, vb_3;

  int n_vec = 0;
  int n_err = 0;
  logic [3*CW-1:0] hist_1 [64];
  logic [3*CW-1:0] hist_3 [64];
  int k_1, k_3;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .HW(4), .VW(3),
    .CLK_DIV(1), .PIPE_LAT(2), .SCALE_LOG2(1), .CW(CW)
  ) u_dut_1 (
    .i_pixel_clk(clk), .i_rst(rst), .o_pix_ce(ce_1), .o_hpos(hpos_1), .o_vpos(vpos_1),
    .o_fb_x(fbx_1), .o_fb_y(fby_1), .o_line_start(ls_1), .o_frame_start(fs_1),
    .i_rgb_in(rgb_in), .i_test_pattern(test_pattern), .o_vr(vr_1), .o_vg(vg_1), .o_vb(vb_1),
    .o_hsync(hs_1), .o_vsync(vs_1), .o_blank(bl_1)
  );

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .HW(4), .VW(3),
    .CLK_DIV(3), .PIPE_LAT(2), .SCALE_LOG2(1), .CW(CW)
  ) u_dut_3 (
    .i_pixel_clk(clk), .i_rst(rst), .o_pix_ce(ce_3), .o_hpos(hpos_3), .o_vpos(vpos_3),
    .o_fb_x(fbx_3), .o_fb_y(fby_3), .o_line_start(ls_3), .o_frame_start(fs_3),
    .i_rgb_in(rgb_in), .i_test_pattern(test_pattern), .o_vr(vr_3), .o_vg(vg_3), .o_vb(vb_3),
    .o_hsync(hs_3), .o_vsync(vs_3), .o_blank(bl_3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // k = clock cycles since reset released; pixel steps taken = k / div.
  task automatic check_dut(input string tag, input int k, input int div,
                           input logic [3*CW-1:0] rgb_at_s,
                           input logic ce, input logic [3:0] hpos, input logic [2:0] vpos,
                           input logic [2:0] fbx, input logic [1:0] fby,
                           input logic ls, input logic fs, input logic bl,
                           input logic hs, input logic vs, input logic [3*CW-1:0] rgb);
    int s, hp, vp, p, php, pvp;
    logic e_ce, e_bl, e_hs, e_vs;
    logic [3*CW-1:0] e_rgb;
    s    = k / div;
    hp   = s % 16;
    vp   = (s / 16) % 8;
    e_ce = (k % div) == div - 1;
    check({tag, ".pix_ce"}, ce, e_ce);
    check({tag, ".hpos"}, hpos, hp);
    check({tag, ".vpos"}, vpos, vp);
    check({tag, ".fb_x"}, fbx, hp / 2);
    check({tag, ".fb_y"}, fby, vp / 2);
    check({tag, ".line_start"}, ls, e_ce && hp == 0);
    check({tag, ".frame_start"}, fs, e_ce && hp == 0 && vp == 0);
    if (s < 3) begin
      e_bl = 1'b1; e_hs = 1'b1; e_vs = 1'b0; e_rgb = '0;
    end else begin
      p    = s - 3;
      php  = p % 16;
      pvp  = (p / 16) % 8;
      e_bl = (php >= 8) || (pvp >= 4);
      e_hs = (php >= 10 && php <= 12) ? 1'b0 : 1'b1;
      e_vs = (pvp >= 5 && pvp <= 6) ? 1'b1 : 1'b0;
      e_rgb = e_bl ? '0 : rgb_at_s;
    end
    check({tag, ".blank"}, bl, e_bl);
    check({tag, ".hsync"}, hs, e_hs);
    check({tag, ".vsync"}, vs, e_vs);
    check({tag, ".rgb"}, rgb, e_rgb);
  endtask

  initial begin
    rst = 1'b1;
    rgb_in = '0;
    test_pattern = 1'b0;
    k_1 = 0;
    k_3 = 0;
    @(negedge clk);
    @(negedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check_dut("div1", k_1, 1, hist_1[k_1 % 64], ce_1, hpos_1, vpos_1, fbx_1, fby_1,
                ls_1, fs_1, bl_1, hs_1, vs_1, {vr_1, vg_1, vb_1});
      check_dut("div3", k_3, 3, hist_3[(k_3 / 3) % 64], ce_3, hpos_3, vpos_3, fbx_3, fby_3,
                ls_3, fs_3, bl_3, hs_3, vs_3, {vr_3, vg_3, vb_3});
      rst = (cyc == 1700) || ($urandom_range(0, 399) == 0);
      rgb_in = 15'($urandom_range(0, 32767));
`ifdef VGA_TEST_PATTERN_EN
      test_pattern = 1'b0;
`else
      test_pattern = 1'($urandom_range(0, 1));
`endif
      if (!rst) begin
        hist_1[(k_1 + 1) % 64] = rgb_in;
        if ((k_3 % 3) == 2) hist_3[(k_3 / 3 + 1) % 64] = rgb_in;
      end
      @(posedge clk);
      if (rst) begin
        k_1 = 0;
        k_3 = 0;
      end else begin
        k_1++;
        k_3++;
      end
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
